reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; register address width is fixed at 5 bits.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning asynchronous active-low reset.
REQ-005 SHALL have port wr_en  input  1  meaning write-back strobe for the current cycle.
REQ-006 SHALL have port wr_addr  input  5  meaning destination register from the write-address select (rt, rd or 31).
REQ-007 SHALL have port wr_data  input  DATA_W  meaning write-back value.
REQ-008 SHALL have port rd_addr_a  input  5  meaning read port A address (rs).
REQ-009 SHALL have port rd_addr_b  input  5  meaning read port B address (rt).
REQ-010 SHALL have port rd_data_a  output  DATA_W  meaning port A read value.
REQ-011 SHALL have port rd_data_b  output  DATA_W  meaning port B read value.
REQ-012 SHALL have port iss_en  input  1  meaning an instruction with a register destination issues this cycle.
REQ-013 SHALL have port iss_addr  input  5  meaning destination of the issuing instruction.
REQ-014 SHALL have port stall  output  1  meaning a read port addresses a register with a write still pending.
REQ-015 SHALL have port pend_cnt  output  6  meaning number of registers currently marked pending.

Function
REQ-016 SHALL write wr_data into register wr_addr on the clock edge when wr_en=1 and wr_addr!=0.
REQ-017 SHALL ignore writes to register 0; register 0 SHALL always read as 0.
REQ-018 SHALL drive read data combinationally from rd_addr_a and rd_addr_b, with zero cycles of latency.
REQ-019 SHALL bypass the write port: when wr_en=1 and wr_addr equals a nonzero read address, that port SHALL return wr_data in the same cycle.
REQ-020 SHALL keep a per-register pending bit: iss_en=1 with iss_addr!=0 sets bit iss_addr on the clock edge.
REQ-021 SHALL clear pending bit wr_addr on the clock edge when wr_en=1.
REQ-022 SHALL leave the bit set when a clear and a set hit the same address in the same cycle (set wins).
REQ-023 SHALL never set the pending bit of register 0.
REQ-024 SHALL assert stall combinationally when rd_addr_a or rd_addr_b is nonzero, its pending bit is set, and it is not being written this cycle (wr_en=1 with matching wr_addr).
REQ-025 SHALL keep pend_cnt equal to the population count of the pending bits, updated on the same edge as the bits.
REQ-026 SHALL ignore set requests to a register that is already pending; pend_cnt SHALL NOT change.
REQ-027 SHALL treat wr_en=1 to a register that is not pending as a normal write with no change to pending state.

Reset
REQ-028 SHALL, while rst_n=0, clear all registers to 0 and all pending bits to 0 asynchronously, and hold pend_cnt=0 and stall=0.
REQ-029 SHALL ignore wr_en and iss_en while rst_n=0; a reset asserted mid-operation SHALL discard all pending writes.
REQ-030 SHALL resume normal operation on the first rising edge after rst_n returns to 1.

Verification
REQ-031 Reset, then read all 32 addresses -> all read 0, stall=0, pend_cnt=0.
REQ-032 Write 0xDEADBEEF to r5, then write 0x12345678 to r0 -> next cycle r5=0xDEADBEEF and r0=0.
REQ-033 wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5 with rd_addr_a=7 in the same cycle -> rd_data_a=0xA5A5A5A5 before the edge.
REQ-034 Issue r9, then read r9 on port B -> stall=1 and pend_cnt=1; write r9 -> stall=0 in the write cycle and pend_cnt=0 after the edge.
REQ-035 Same cycle: issue r3 and write r3 while r3 is pending -> r3 stays pending and pend_cnt is unchanged.
REQ-036 Issue r1, r2 and r31, then pulse rst_n low mid-sequence -> pend_cnt=0, stall=0, and all registers read 0.

Source files
------------

// File: rtl/reg_file.sv
// Two-read, one-write register file with a per-register pending scoreboard.
// Reads are combinational with write-port bypass; register 0 is hardwired to zero.
module reg_file #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              iss_en,
    input  logic [4:0]        iss_addr,
    output logic              stall,
    output logic [5:0]        pend_cnt
);

    localparam logic [5:0] NREGS_L = 6'(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  pend_q;
    logic [NREGS-1:0]  pend_d;
    logic [5:0]        cnt_q;
    logic [5:0]        cnt_d;

    logic              wr_we;
    logic              byp_en;
    logic [4:0]        port_addr  [2];
    logic [DATA_W-1:0] port_data  [2];
    logic [1:0]        port_stall;

    assign wr_we  = wr_en && (wr_addr != 5'd0) && ({1'b0, wr_addr} < NREGS_L);
    // Bypass is suppressed during reset so a reset file reads all zeros.
    assign byp_en = wr_en && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_we) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Pending next state: a clear from write-back and a set from issue; set wins.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_pend
        logic set_bit;
        logic clr_bit;
        assign set_bit    = iss_en && (iss_addr == 5'(gi)) && (gi != 0);
        assign clr_bit    = wr_en && (wr_addr == 5'(gi));
        assign pend_d[gi] = set_bit | (pend_q[gi] & ~clr_bit);
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + 6'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign port_addr[0] = rd_addr_a;
    assign port_addr[1] = rd_addr_b;

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic valid;
        logic wr_hit;
        assign valid  = (port_addr[gi] != 5'd0) && ({1'b0, port_addr[gi]} < NREGS_L);
        assign wr_hit = wr_en && (wr_addr == port_addr[gi]);
        assign port_data[gi] = !valid            ? '0      :
                               (wr_hit && byp_en) ? wr_data :
                               regs_q[port_addr[gi]];
        // A register being written this cycle is already resolved by the bypass.
        assign port_stall[gi] = valid && pend_q[port_addr[gi]] && !wr_hit;
    end

    assign rd_data_a = port_data[0];
    assign rd_data_b = port_data[1];
    assign stall     = |port_stall;
    assign pend_cnt  = cnt_q;

endmodule
